// File: rtl/ps2key_pc8001_matrix.sv
// ps2key_pc8001_matrix
//   Turns the hps_io ps2_key event word into the PC-8001 10x8 keyboard matrix
//   that pc8001m reads through its keyboard ports 00h-09h. Every press stays
//   visible for at least HOLD_CYCLES clocks. A release that arrives inside that
//   window is parked in a small FIFO and applied once the hold timer expires.
// Ports
//   clk_sys  : system clock (only clock)
//   reset_n  : synchronous active-low reset
//   ps2_key  : [10] toggle strobe, [9] press, [8] E0 prefix, [7:0] set-2 code
//   kbd_row  : matrix row selected by the CPU
//   kbd_data : active-low column bits of kbd_row (0 = key down)
//   rel_ovf  : sticky flag, a release arrived while the FIFO was full
module ps2key_pc8001_matrix #(
    parameter int HOLD_CYCLES = 1000000,
    parameter int REL_DEPTH   = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [3:0]  kbd_row,
    output logic [7:0]  kbd_data,
    output logic        rel_ovf
);
    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);
    localparam int PTR_W   = $clog2(REL_DEPTH);

    // Matrix entry: {hit, row[3:0], bit[2:0]}
    function automatic logic [7:0] km(input int r, input int b);
        return {1'b1, 4'(r), 3'(b)};
    endfunction

    function automatic logic [7:0] key_lookup(input logic [8:0] key);
        logic [7:0] res;
        case (key)
            // row 0: keypad 0-7
            9'h070: res = km(0, 0);  9'h069: res = km(0, 1);  9'h072: res = km(0, 2);  9'h07A: res = km(0, 3);
            9'h06B: res = km(0, 4);  9'h073: res = km(0, 5);  9'h074: res = km(0, 6);  9'h06C: res = km(0, 7);
            // row 1: keypad 8 9 * + . and RETURN (main and keypad Enter)
            9'h075: res = km(1, 0);  9'h07D: res = km(1, 1);  9'h07C: res = km(1, 2);  9'h079: res = km(1, 3);
            9'h071: res = km(1, 6);  9'h05A: res = km(1, 7);  9'h15A: res = km(1, 7);
            // row 2: @ A-G (backtick stands in for @)
            9'h00E: res = km(2, 0);  9'h01C: res = km(2, 1);  9'h032: res = km(2, 2);  9'h021: res = km(2, 3);
            9'h023: res = km(2, 4);  9'h024: res = km(2, 5);  9'h02B: res = km(2, 6);  9'h034: res = km(2, 7);
            // row 3: H-O
            9'h033: res = km(3, 0);  9'h043: res = km(3, 1);  9'h03B: res = km(3, 2);  9'h042: res = km(3, 3);
            9'h04B: res = km(3, 4);  9'h03A: res = km(3, 5);  9'h031: res = km(3, 6);  9'h044: res = km(3, 7);
            // row 4: P-W
            9'h04D: res = km(4, 0);  9'h015: res = km(4, 1);  9'h02D: res = km(4, 2);  9'h01B: res = km(4, 3);
            9'h02C: res = km(4, 4);  9'h03C: res = km(4, 5);  9'h02A: res = km(4, 6);  9'h01D: res = km(4, 7);
            // row 5: X Y Z [ \ ] ^(=) -
            9'h022: res = km(5, 0);  9'h035: res = km(5, 1);  9'h01A: res = km(5, 2);  9'h054: res = km(5, 3);
            9'h05D: res = km(5, 4);  9'h05B: res = km(5, 5);  9'h055: res = km(5, 6);  9'h04E: res = km(5, 7);
            // row 6: digits 0-7
            9'h045: res = km(6, 0);  9'h016: res = km(6, 1);  9'h01E: res = km(6, 2);  9'h026: res = km(6, 3);
            9'h025: res = km(6, 4);  9'h02E: res = km(6, 5);  9'h036: res = km(6, 6);  9'h03D: res = km(6, 7);
            // row 7: 8 9 :(') ; , . / _
            9'h03E: res = km(7, 0);  9'h046: res = km(7, 1);  9'h052: res = km(7, 2);  9'h04C: res = km(7, 3);
            9'h041: res = km(7, 4);  9'h049: res = km(7, 5);  9'h04A: res = km(7, 6);  9'h14A: res = km(7, 6);
            9'h051: res = km(7, 7);
            // row 8: HOME UP RIGHT INS/DEL GRPH(Alt) KANA(Caps) SHIFT CTRL
            9'h16C: res = km(8, 0);  9'h175: res = km(8, 1);  9'h174: res = km(8, 2);  9'h171: res = km(8, 3);
            9'h170: res = km(8, 3);  9'h066: res = km(8, 3);  9'h011: res = km(8, 4);  9'h111: res = km(8, 4);
            9'h058: res = km(8, 5);  9'h012: res = km(8, 6);  9'h059: res = km(8, 6);  9'h014: res = km(8, 7);
            9'h114: res = km(8, 7);
            // row 9: STOP(F10) F1-F5 SPACE ESC
            9'h009: res = km(9, 0);  9'h005: res = km(9, 1);  9'h006: res = km(9, 2);  9'h004: res = km(9, 3);
            9'h00C: res = km(9, 4);  9'h003: res = km(9, 5);  9'h029: res = km(9, 6);  9'h076: res = km(9, 7);
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    // Stage 1: capture
    logic       toggle_q, ev_v_q, ev_press_q;
    logic [8:0] ev_key_q;
    // Stage 2: lookup
    logic       lk_v_q, lk_press_q;
    logic [3:0] lk_row_q;
    logic [2:0] lk_bit_q;
    logic [7:0] lk_res;
    // Stage 3: matrix, hold timer, deferred-release FIFO
    logic [7:0]         matrix_q [10];
    logic [7:0]         matrix_d [10];
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [6:0]         fifo_mem [REL_DEPTH];
    logic               ovf_q, ovf_d;

    logic       fifo_empty, fifo_full, timer_zero;
    logic       rel_ev, do_push, do_pop, rel_now;
    logic [6:0] pop_entry;

    assign lk_res = key_lookup(ev_key_q);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            // Adopt the current strobe level so a toggle seen during reset is ignored.
            toggle_q   <= ps2_key[10];
            ev_v_q     <= 1'b0;
            ev_press_q <= 1'b0;
            ev_key_q   <= '0;
            lk_v_q     <= 1'b0;
            lk_press_q <= 1'b0;
            lk_row_q   <= '0;
            lk_bit_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            toggle_q <= ps2_key[10];
            ev_v_q   <= ps2_key[10] != toggle_q;
            if (ps2_key[10] != toggle_q) begin
                ev_press_q <= ps2_key[9];
                ev_key_q   <= ps2_key[8:0];
            end
            lk_v_q     <= ev_v_q && lk_res[7];   // unmapped keys vanish here
            lk_press_q <= ev_press_q;
            lk_row_q   <= lk_res[6:3];
            lk_bit_q   <= lk_res[2:0];
        end
    end

    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign timer_zero = timer_q == '0;
    assign do_pop     = timer_zero && !fifo_empty;
    assign rel_ev     = lk_v_q && !lk_press_q;
    // Defer a release while a hold is running or older releases are still queued,
    // unless there is no room left, in which case it is applied at once.
    assign do_push    = rel_ev && !(timer_zero && fifo_empty) && !fifo_full;
    assign rel_now    = rel_ev && !do_push;
    assign pop_entry  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        matrix_d = matrix_q;
        timer_d  = timer_zero ? timer_q : timer_q - TIMER_W'(1);
        ovf_d    = ovf_q || (rel_ev && fifo_full);
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
        if (do_pop)
            matrix_d[pop_entry[6:3]][pop_entry[2:0]] = 1'b0;
        if (rel_now)
            matrix_d[lk_row_q][lk_bit_q] = 1'b0;
        // Applied last so a press beats a pop aimed at the same bit.
        if (lk_v_q && lk_press_q) begin
            matrix_d[lk_row_q][lk_bit_q] = 1'b1;
            timer_d = TIMER_W'(HOLD_CYCLES);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            matrix_q <= '{default: '0};
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            matrix_q <= matrix_d;
            timer_q  <= timer_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (reset_n && do_push)
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {lk_row_q, lk_bit_q};
    end

    always_comb begin
        kbd_data = 8'hFF;
        if (kbd_row < 4'd10)
            kbd_data = ~matrix_q[kbd_row];
    end

    assign rel_ovf = ovf_q;
endmodule
